// File: rtl/nios_onchip_ram_dp.sv
// True-dual-port on-chip RAM with two Avalon-MM slaves, pipelined reads and
// same-address write arbitration (s1 wins, s2 is stalled one cycle and retries).
module nios_onchip_ram_dp #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 13,
    parameter int DEPTH        = 5120,
    parameter int READ_LATENCY = 1,
    parameter     INIT_FILE    = "nios_onchip_ram.hex"
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    reset_req,
    input  logic                    clken,
    input  logic [ADDR_WIDTH-1:0]   s1_address,
    input  logic                    s1_chipselect,
    input  logic                    s1_read,
    input  logic                    s1_write,
    input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
    input  logic [DATA_WIDTH-1:0]   s1_writedata,
    output logic                    s1_waitrequest,
    output logic [DATA_WIDTH-1:0]   s1_readdata,
    output logic                    s1_readdatavalid,
    input  logic [ADDR_WIDTH-1:0]   s2_address,
    input  logic                    s2_chipselect,
    input  logic                    s2_read,
    input  logic                    s2_write,
    input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
    input  logic [DATA_WIDTH-1:0]   s2_writedata,
    output logic                    s2_waitrequest,
    output logic [DATA_WIDTH-1:0]   s2_readdata,
    output logic                    s2_readdatavalid,
    output logic                    oob_err
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

    if (DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
        $error("nios_onchip_ram_dp: DEPTH %0d exceeds 2**ADDR_WIDTH (image %s)", DEPTH, INIT_FILE);
    end
    if (DATA_WIDTH % 8 != 0) begin : g_bad_width
        $error("nios_onchip_ram_dp: DATA_WIDTH %0d is not a multiple of 8", DATA_WIDTH);
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("nios_onchip_ram_dp: READ_LATENCY %0d must be 1 or 2", READ_LATENCY);
    end

    logic                  en;
    logic                  collide;
    logic [1:0]            cs, rd, wr, wt, in_range, acc_rd, acc_wr;
    logic [ADDR_WIDTH-1:0] addr  [2];
    logic [IDX_W-1:0]      idx   [2];
    logic [NB-1:0]         be    [2];
    logic [DATA_WIDTH-1:0] wdata [2];
    logic [DATA_WIDTH-1:0] mem   [DEPTH];
    logic [1:0]            v1;
    logic [DATA_WIDTH-1:0] d1    [2];

    assign cs       = {s2_chipselect, s1_chipselect};
    assign rd       = {s2_read, s1_read};
    assign wr       = {s2_write, s1_write};
    assign addr[0]  = s1_address;
    assign addr[1]  = s2_address;
    assign be[0]    = s1_byteenable;
    assign be[1]    = s2_byteenable;
    assign wdata[0] = s1_writedata;
    assign wdata[1] = s2_writedata;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            idx[p]      = addr[p][IDX_W-1:0];
            in_range[p] = ({1'b0, addr[p]} < DEPTH_LIM);
        end
    end

    assign en      = clken & ~reset_req;
    // s1 has priority on a same-word write; s2 sees the stall combinationally
    assign collide = cs[0] & wr[0] & cs[1] & wr[1] & (addr[0] == addr[1]) & in_range[0];
    assign wt      = {~en | collide, ~en};
    assign acc_wr  = {2{en & ~reset}} & cs & wr & ~wt;
    assign acc_rd  = {2{en & ~reset}} & cs & rd & ~wr & ~wt;

    assign s1_waitrequest = wt[0];
    assign s2_waitrequest = wt[1];

    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            for (int b = 0; b < NB; b++) begin
                if (acc_wr[p] && in_range[p] && be[p][b]) begin
                    mem[idx[p]][8*b +: 8] <= wdata[p][8*b +: 8];
                end
            end
        end
    end

    // Read stage samples the array before this edge's writes land: old data on collision
    always_ff @(posedge clk) begin
        if (reset) begin
            v1 <= '0;
            for (int p = 0; p < 2; p++) begin
                d1[p] <= '0;
            end
        end else if (en) begin
            v1 <= acc_rd;
            for (int p = 0; p < 2; p++) begin
                if (acc_rd[p]) begin
                    d1[p] <= in_range[p] ? mem[idx[p]] : '0;
                end
            end
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic [1:0]            v2;
        logic [DATA_WIDTH-1:0] d2 [2];

        always_ff @(posedge clk) begin
            if (reset) begin
                v2 <= '0;
                for (int p = 0; p < 2; p++) begin
                    d2[p] <= '0;
                end
            end else if (en) begin
                v2 <= v1;
                for (int p = 0; p < 2; p++) begin
                    d2[p] <= d1[p];
                end
            end
        end

        assign s1_readdatavalid = v2[0];
        assign s2_readdatavalid = v2[1];
        assign s1_readdata      = d2[0];
        assign s2_readdata      = d2[1];
    end else begin : g_lat1
        assign s1_readdatavalid = v1[0];
        assign s2_readdatavalid = v1[1];
        assign s1_readdata      = d1[0];
        assign s2_readdata      = d1[1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            oob_err <= 1'b0;
        end else if (|((acc_rd | acc_wr) & ~in_range)) begin
            oob_err <= 1'b1;
        end
    end
endmodule
